// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the decoder/mux slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  function automatic logic is_transfer(input logic [1:0] trans);
    return (htrans_e'(trans) == HTRANS_NONSEQ) || (htrans_e'(trans) == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_resp_mux.sv
// One-hot response mux; an all-zero select means no data phase is in flight.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [NUM_SLAVES:0]              sel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] rdata_s,
  input  logic [NUM_SLAVES*2-1:0]          resp_s,
  input  logic [NUM_SLAVES-1:0]            readyout_s,
  input  logic [DATA_WIDTH-1:0]            rdata_def,
  input  logic [1:0]                       resp_def,
  input  logic                             readyout_def,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       resp,
  output logic                             ready
);

  // AND-OR form relies on sel being one-hot or zero.
  always_comb begin
    rdata = '0;
    resp  = HRESP_OKAY;
    ready = ~|sel;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel[i]) begin
        rdata = rdata | rdata_s[i*DATA_WIDTH +: DATA_WIDTH];
        resp  = resp | resp_s[i*2 +: 2];
        ready = ready | readyout_s[i];
      end
    end
    if (sel[NUM_SLAVES]) begin
      rdata = rdata | rdata_def;
      resp  = resp | resp_def;
      ready = ready | readyout_def;
    end
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase owner tracking, response routing
// and a saturating decode-error counter.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_BITS   = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic                             HREADY,
  output logic [NUM_SLAVES-1:0]            HSEL_S,
  output logic                             HSEL_DEF,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES*2-1:0]          HRESP_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [DATA_WIDTH-1:0]            HRDATA_DEF,
  input  logic [1:0]                       HRESP_DEF,
  input  logic                             HREADYOUT_DEF,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [1:0]                       HRESP,
  output logic [CNT_WIDTH-1:0]             dec_err_count
);

  logic [SEL_BITS-1:0]   region;
  logic [NUM_SLAVES:0]   dp_sel;
  logic                  active;
  logic                  unused_addr;

  assign region      = HADDR[ADDR_WIDTH-1 -: SEL_BITS];
  assign active      = is_transfer(HTRANS);
  assign unused_addr = ^HADDR[ADDR_WIDTH-SEL_BITS-1:0];

  always_comb begin
    HSEL_S = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (region == SEL_BITS'(i)) HSEL_S[i] = 1'b1;
    end
    HSEL_DEF = ~|HSEL_S;
  end

  // Ownership only advances when the current data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_sel <= '0;
    end else if (HREADY) begin
      dp_sel <= active ? {HSEL_DEF, HSEL_S} : '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dec_err_count <= '0;
    end else if (HREADY && active && HSEL_DEF && (dec_err_count != '1)) begin
      dec_err_count <= dec_err_count + 1'b1;
    end
  end

  ahb_resp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_mux (
    .sel          (dp_sel),
    .rdata_s      (HRDATA_S),
    .resp_s       (HRESP_S),
    .readyout_s   (HREADYOUT_S),
    .rdata_def    (HRDATA_DEF),
    .resp_def     (HRESP_DEF),
    .readyout_def (HREADYOUT_DEF),
    .rdata        (HRDATA),
    .resp         (HRESP),
    .ready        (HREADY)
  );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed table-driven bench for ahb_decoder_mux plus reset corner sequences.
module tb_ahb_decoder_mux;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [127:0] HRDATA_S;
  logic [7:0]  HRESP_S;
  logic [3:0]  HREADYOUT_S;
  logic [31:0] HRDATA_DEF;
  logic [1:0]  HRESP_DEF;
  logic        HREADYOUT_DEF;

  logic        HREADY, HSEL_DEF;
  logic [3:0]  HSEL_S;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic [7:0]  cnt;

  logic        r2_ready, r2_def;
  logic [3:0]  r2_sel;
  logic [31:0] r2_data;
  logic [1:0]  r2_resp;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_BITS(4), .CNT_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(HREADY),
    .HSEL_S(HSEL_S), .HSEL_DEF(HSEL_DEF), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S),
    .HREADYOUT_S(HREADYOUT_S), .HRDATA_DEF(HRDATA_DEF), .HRESP_DEF(HRESP_DEF),
    .HREADYOUT_DEF(HREADYOUT_DEF), .HRDATA(HRDATA), .HRESP(HRESP), .dec_err_count(cnt)
  );

  ahb_decoder_mux #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_BITS(4), .CNT_WIDTH(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(r2_ready),
    .HSEL_S(r2_sel), .HSEL_DEF(r2_def), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S),
    .HREADYOUT_S(HREADYOUT_S), .HRDATA_DEF(HRDATA_DEF), .HRESP_DEF(HRESP_DEF),
    .HREADYOUT_DEF(HREADYOUT_DEF), .HRDATA(r2_data), .HRESP(r2_resp), .dec_err_count(cnt2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  rdy_s;
    logic [1:0]  resp_def;
    logic        rdy_def;
    logic [3:0]  e_sel;
    logic        e_def;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
    logic [1:0]  e_cnt2;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] trans,
                              input logic [3:0] rdy_s, input logic [1:0] resp_def,
                              input logic rdy_def, input logic [3:0] e_sel, input logic e_def,
                              input logic e_rdy, input logic [1:0] e_resp,
                              input logic [31:0] e_data, input logic [7:0] e_cnt,
                              input logic [1:0] e_cnt2);
    vec_t v;
    v.addr = addr; v.trans = trans; v.rdy_s = rdy_s; v.resp_def = resp_def;
    v.rdy_def = rdy_def; v.e_sel = e_sel; v.e_def = e_def; v.e_rdy = e_rdy;
    v.e_resp = e_resp; v.e_data = e_data; v.e_cnt = e_cnt; v.e_cnt2 = e_cnt2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " hsel_s"},   32'(HSEL_S),   32'(v.e_sel));
    chk({tag, " hsel_def"}, 32'(HSEL_DEF), 32'(v.e_def));
    chk({tag, " hready"},   32'(HREADY),   32'(v.e_rdy));
    chk({tag, " hresp"},    32'(HRESP),    32'(v.e_resp));
    chk({tag, " hrdata"},   HRDATA,        v.e_data);
    chk({tag, " count"},    32'(cnt),      32'(v.e_cnt));
    chk({tag, " count2"},   32'(cnt2),     32'(v.e_cnt2));
    chk({tag, " d2 ready"}, 32'(r2_ready), 32'(v.e_rdy));
    chk({tag, " d2 data"},  r2_data,       v.e_data);
    chk({tag, " d2 sel"},   32'({r2_def, r2_sel, r2_resp}), 32'({v.e_def, v.e_sel, v.e_resp}));
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    vec_t v;
    localparam logic [31:0] D1 = 32'hA000_0001;
    localparam logic [31:0] D3 = 32'hA000_0003;
    localparam logic [31:0] DD = 32'hDEF0_DEF0;
    localparam logic [31:0] CF = 32'hCAFE_F00D;

    vecs[0]  = mk(32'h2000_0004, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0100, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0, 2'd0);
    vecs[1]  = mk(32'h1000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1, 2'b00, CF,    8'd0, 2'd0);
    vecs[2]  = mk(32'h3000_0000, 2'b10, 4'b1101, 2'b00, 1'b1, 4'b1000, 1'b0, 1'b0, 2'b00, D1,    8'd0, 2'd0);
    vecs[3]  = mk(32'h3000_0000, 2'b10, 4'b1101, 2'b00, 1'b1, 4'b1000, 1'b0, 1'b0, 2'b00, D1,    8'd0, 2'd0);
    vecs[4]  = mk(32'h3000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b1000, 1'b0, 1'b1, 2'b00, D1,    8'd0, 2'd0);
    vecs[5]  = mk(32'hF000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, D3,    8'd0, 2'd0);
    vecs[6]  = mk(32'h0000_0000, 2'b00, 4'b1111, 2'b01, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, DD,    8'd1, 2'd1);
    vecs[7]  = mk(32'h0000_0000, 2'b00, 4'b1111, 2'b01, 1'b1, 4'b0001, 1'b0, 1'b1, 2'b01, DD,    8'd1, 2'd1);
    vecs[8]  = mk(32'hF000_0000, 2'b00, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, 32'h0, 8'd1, 2'd1);
    vecs[9]  = mk(32'hF000_0000, 2'b01, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, 32'h0, 8'd1, 2'd1);
    vecs[10] = mk(32'h4000_0000, 2'b11, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, 32'h0, 8'd1, 2'd1);
    vecs[11] = mk(32'h5000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, DD,    8'd2, 2'd2);
    vecs[12] = mk(32'hF000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, DD,    8'd3, 2'd3);
    vecs[13] = mk(32'hF000_0000, 2'b10, 4'b1111, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b00, DD,    8'd4, 2'd3);
    vecs[14] = mk(32'h3FFF_FFFC, 2'b00, 4'b1111, 2'b00, 1'b1, 4'b1000, 1'b0, 1'b1, 2'b00, DD,    8'd5, 2'd3);
    vecs[15] = mk(32'h0000_0000, 2'b00, 4'b1111, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 2'b00, 32'h0, 8'd5, 2'd3);

    HRDATA_S      = {32'hA000_0003, CF, 32'hA000_0001, 32'hA000_0000};
    HRESP_S       = '0;
    HREADYOUT_S   = 4'b1111;
    HRDATA_DEF    = DD;
    HRESP_DEF     = 2'b00;
    HREADYOUT_DEF = 1'b1;
    HTRANS        = 2'b00;
    HADDR         = 32'h1000_0000;
    HRESETn       = 1'b0;

    #7;
    v = mk(32'h1000_0000, 2'b00, 4'b1111, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0, 2'd0);
    chk_outputs("reset", v);
    #1 HRESETn = 1'b1;
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      HADDR         = vecs[i].addr;
      HTRANS        = vecs[i].trans;
      HREADYOUT_S   = vecs[i].rdy_s;
      HRESP_DEF     = vecs[i].resp_def;
      HREADYOUT_DEF = vecs[i].rdy_def;
      #2;
      chk_outputs($sformatf("vec%0d", i), vecs[i]);
      next_cycle();
    end

    // Reset asserted while slave1 holds a wait state with an ERROR response pending.
    HADDR = 32'h1000_0000; HTRANS = 2'b10; HREADYOUT_S = 4'b1111;
    next_cycle();
    HTRANS = 2'b00; HREADYOUT_S = 4'b1101; HRESP_S = 8'b0000_0100;
    #2;
    chk("wait hready", 32'(HREADY), 32'h0);
    chk("wait hresp",  32'(HRESP),  32'h1);
    HRESETn = 1'b0;
    #1;
    chk("async hready", 32'(HREADY), 32'h1);
    chk("async hresp",  32'(HRESP),  32'h0);
    chk("async hrdata", HRDATA,      32'h0);
    chk("async count",  32'(cnt),    32'h0);
    chk("async count2", 32'(cnt2),   32'h0);
    next_cycle();
    HRESETn = 1'b1; HRESP_S = '0; HREADYOUT_S = 4'b1111;
    HADDR = 32'h2000_0000; HTRANS = 2'b10;
    #2;
    chk("post rst sel", 32'(HSEL_S), 32'h4);
    next_cycle();
    HTRANS = 2'b00;
    #2;
    chk("post rst data",  HRDATA,         CF);
    chk("post rst ready", 32'(HREADY),    32'h1);
    chk("post rst count", 32'(cnt),       32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
